// File: rtl/sc_exec_monitor.sv
// sc_exec_monitor: commit-side execution monitor with cycle/retire counters, register-write trace FIFO,
// one watched memory word and autonomous pass/fail/timeout decision.
module sc_exec_monitor #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 1000,
  parameter int STALL_LIMIT = 4,
  parameter int TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              rf_we,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] watch_addr,
  input  logic [DATA_W-1:0] expect_val,
  input  logic              trace_rd,
  output logic              trace_valid,
  output logic [REG_AW-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic              trace_ovf,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [DATA_W-1:0] watch_val,
  output logic              done,
  output logic              pass,
  output logic              timeout
);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_prev_pc;
  logic [SW-1:0]     r_stall;
  logic              r_watch_seen;
  logic [REG_AW-1:0] r_taddr [TRACE_DEPTH];
  logic [DATA_W-1:0] r_tdata [TRACE_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  logic              w_run, w_same, w_halt, w_tmo, w_hit, w_seen_next;
  logic              w_full, w_push, w_pop, w_push_ok;
  logic [DATA_W-1:0] w_val_next;
  assign w_run       = r_state == RUN;
  assign w_same      = pc == r_prev_pc;
  assign w_halt      = w_run && w_same && r_stall == SW'(STALL_LIMIT - 1);
  assign w_tmo       = w_run && cycle_cnt == CNT_W'(MAX_CYCLES - 1);
  assign w_hit       = w_run && mem_we && mem_addr == watch_addr;
  assign w_seen_next = r_watch_seen || w_hit;
  assign w_val_next  = w_hit ? mem_wdata : watch_val;
  assign trace_valid = r_count != '0;
  assign w_full      = r_count == (PW+1)'(TRACE_DEPTH);
  assign w_pop       = trace_rd && trace_valid;
  assign w_push      = w_run && rf_we && rf_waddr != '0;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign trace_addr  = trace_valid ? r_taddr[r_rptr] : '0;
  assign trace_data  = trace_valid ? r_tdata[r_rptr] : '0;
  always_ff @(posedge clk)
    if (w_push_ok) begin
      r_taddr[r_wptr] <= rf_waddr;
      r_tdata[r_wptr] <= rf_wdata;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_prev_pc    <= '0;
      r_stall      <= '0;
      r_watch_seen <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      trace_ovf    <= 1'b0;
      cycle_cnt    <= '0;
      retire_cnt   <= '0;
      watch_val    <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop);
      if (w_push && !w_push_ok) trace_ovf <= 1'b1;
      if (r_state == IDLE) begin
        r_prev_pc <= pc;
        r_state   <= RUN;
      end else if (w_run) begin
        cycle_cnt  <= cycle_cnt + CNT_W'(1);
        retire_cnt <= retire_cnt + CNT_W'(!w_same);
        r_stall    <= !w_same ? '0 : r_stall == SW'(STALL_LIMIT) ? r_stall : r_stall + SW'(1);
        r_prev_pc  <= pc;
        if (w_hit) begin
          watch_val    <= mem_wdata;
          r_watch_seen <= 1'b1;
        end
        if (w_halt || w_tmo) begin
          r_state <= DONE;
          done    <= 1'b1;
          timeout <= w_tmo && !w_halt;
          pass    <= !w_tmo && w_seen_next && w_val_next == expect_val;
        end
      end
    end
endmodule

// File: tb/tb_sc_exec_monitor.sv
// tb_sc_exec_monitor: directed and randomized checks of sc_exec_monitor against a queue-based behavioural model.
module tb_sc_exec_monitor;
  localparam int MAXC = 20;
  localparam int SL = 4;
  localparam int DEPTH = 8;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc = '0, rf_wdata = '0, mem_addr = '0, mem_wdata = '0, watch_addr = '0, expect_val = '0;
  logic [4:0] rf_waddr = '0;
  logic rf_we = 1'b0, mem_we = 1'b0, trace_rd = 1'b0;
  logic trace_valid, trace_ovf, done, pass, timeout;
  logic [4:0] trace_addr;
  logic [31:0] trace_data, cycle_cnt, retire_cnt, watch_val;
  int n_tests = 0, n_fail = 0;
  string scen = "";
  bit m_live, m_done, m_seen, m_pass, m_tmo, m_ovf;
  int m_cyc, m_ret, m_eq;
  logic [31:0] m_prev, m_wval;
  ent_t m_q[$];

  sc_exec_monitor #(.MAX_CYCLES(MAXC), .STALL_LIMIT(SL), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .watch_addr(watch_addr),
    .expect_val(expect_val), .trace_rd(trace_rd), .trace_valid(trace_valid), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_ovf(trace_ovf), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .watch_val(watch_val), .done(done), .pass(pass), .timeout(timeout));

  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", scen, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    {m_live, m_done, m_seen, m_pass, m_tmo, m_ovf} = '0;
    m_cyc = 0; m_ret = 0; m_eq = 0; m_prev = '0; m_wval = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit full, pop, push;
    full = m_q.size() == DEPTH;
    pop = trace_rd && m_q.size() != 0;
    push = m_live && !m_done && rf_we && rf_waddr != 0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full || pop) m_q.push_back({rf_waddr, rf_wdata});
      else m_ovf = 1;
    end
    if (!m_live) begin
      m_prev = pc;
      m_live = 1;
    end else if (!m_done) begin
      m_cyc++;
      if (pc == m_prev) m_eq++;
      else begin m_eq = 0; m_ret++; end
      m_prev = pc;
      if (mem_we && mem_addr == watch_addr) begin m_wval = mem_wdata; m_seen = 1; end
      if (m_eq >= SL || m_cyc == MAXC) begin
        m_done = 1;
        m_tmo = m_cyc == MAXC && m_eq < SL;
        m_pass = m_cyc != MAXC && m_seen && m_wval == expect_val;
      end
    end
  endtask

  task automatic compare_all();
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("timeout", timeout, m_tmo);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("retire_cnt", retire_cnt, m_ret);
    chk("watch_val", watch_val, m_wval);
    chk("trace_ovf", trace_ovf, m_ovf);
    chk("trace_valid", trace_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("trace_addr", trace_addr, m_q[0].a);
      chk("trace_data", trace_data, m_q[0].d);
    end
  endtask

  task automatic tick(input logic [31:0] p, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mw, input logic [31:0] ma, input logic [31:0] md, input logic rd);
    pc = p; rf_we = we; rf_waddr = wa; rf_wdata = wd;
    mem_we = mw; mem_addr = ma; mem_wdata = md; trace_rd = rd;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic start(input string name, input logic [31:0] wa, input logic [31:0] ev);
    scen = name;
    rst = 1'b1;
    {rf_we, mem_we, trace_rd} = '0;
    pc = '0; watch_addr = wa; expect_val = ev;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_program(input logic [31:0] ev);
    start("prog", 32'd84, ev);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) tick(4 * i, 0, 0, 0, 4 * i == 32'h20, 84, 32'h2A, 0);
    for (int i = 0; i < 10 && !done; i++) tick(32'h28, 0, 0, 0, 0, 0, 0, 0);
    chk("prog_done", done, 1);
    chk("prog_retire", retire_cnt, 10);
    chk("prog_watch", watch_val, 32'h2A);
    chk("prog_pass", pass, ev == 32'h2A);
    chk("prog_timeout", timeout, 0);
  endtask

  initial begin
    int regs[11] = '{1, 2, 3, 4, 5, 0, 6, 7, 8, 9, 10};
    start("halt0", 32'd84, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt0_early", done, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt0_done", done, 1);
    chk("halt0_cyc", cycle_cnt, 4);
    chk("halt0_pass", pass, 0);

    run_program(32'h2A);
    run_program(32'h2B);

    start("tmo", 32'd84, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 30 && !done; i++) tick(4 * i, 0, 0, 0, 0, 0, 0, 0);
    chk("tmo_done", done, 1);
    chk("tmo_flag", timeout, 1);
    chk("tmo_cyc", cycle_cnt, MAXC);
    repeat (3) tick(32'h400, 1, 3, 7, 1, 84, 1, 0);

    start("trace", 32'd84, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) tick(4 * (i + 1), 1, 5'(regs[i]), 3 * regs[i], 0, 0, 0, 0);
    chk("trace_ovf_set", trace_ovf, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("trace_pop_addr", trace_addr, i);
      chk("trace_pop_data", trace_data, 3 * i);
      tick(4 * (12 + i), 0, 0, 0, 0, 0, 0, 1);
    end
    chk("trace_empty", trace_valid, 0);

    start("midrst", 32'd84, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) tick(4 * i, i <= 3, 5'(i), i, 0, 0, 0, 0);
    chk("midrst_cyc7", cycle_cnt, 7);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 rst = 1'b0;
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    tick(4, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_restart", cycle_cnt, 1);

    for (int r = 0; r < 12; r++) begin
      int hold, extra;
      logic [31:0] p;
      start("rand", 32'h40 + 4 * $urandom_range(0, 2), $urandom_range(0, 3));
      hold = $urandom_range(1, 3);
      p = 4 * $urandom_range(0, 15);
      tick(p, 0, 0, 0, 0, 0, 0, 0);
      extra = 0;
      for (int k = 0; k < 80 && extra < 6; k++) begin
        if ($urandom_range(0, 3) >= hold) p = 4 * $urandom_range(0, 15);
        tick(p, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 2) == 0, 32'h40 + 4 * $urandom_range(0, 2), $urandom_range(0, 3),
             $urandom_range(0, 2) == 0);
        if (m_done) extra++;
      end
      chk("rand_done", done, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
